// File: rtl/pipelined_add_sub_pkg.sv
// Shared definitions for the pipelined add/subtract unit.
//   OP_ADD / OP_SUB : encodings of the 'sub' mode input, used by the
//                     decoder that drives the unit.
//   signed_ovf      : two's-complement overflow from the operand and
//                     result sign bits.
package pipelined_add_sub_pkg;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  // Operand signs agree, but the result sign differs from them.
  // The B sign passed in must be the effective (possibly inverted) operand.
  function automatic logic signed_ovf(input logic a_msb, input logic b_msb,
                                      input logic s_msb);
    return (a_msb == b_msb) && (s_msb != a_msb);
  endfunction

endpackage

// File: rtl/add_chunk.sv
// One carry-chain slice of the pipelined adder. Purely combinational.
//   a, b : C-bit operand slices
//   cin  : carry into the slice
//   s    : C-bit sum slice
//   cout : carry out of the slice
module add_chunk #(
  parameter int C = 8
) (
  input  logic [C-1:0] a,
  input  logic [C-1:0] b,
  input  logic         cin,
  output logic [C-1:0] s,
  output logic         cout
);

  assign {cout, s} = {1'b0, a} + {1'b0, b} + {{C{1'b0}}, cin};

endmodule

// File: rtl/pipelined_add_sub.sv
// Pipelined integer add/subtract unit. The WIDTH-bit carry chain is cut
// into STAGES slices; stage k resolves slice k using the carry registered
// by stage k-1, so a wide add closes timing at one slice per cycle.
// The whole pipe advances together whenever the output slot is free or
// being consumed.
//   clk, reset          : clock, synchronous active-high reset
//   in_valid / in_ready : operation handshake (a, b, sub, tag_in)
//   out_valid/out_ready : result handshake (sum, carry, overflow, zero,
//                         tag_out)
//   busy                : some stage holds a live operation
module pipelined_add_sub
  import pipelined_add_sub_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int STAGES = 4,
  parameter int TAG_W  = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  input  logic [TAG_W-1:0] tag_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             carry,
  output logic             overflow,
  output logic             zero,
  output logic [TAG_W-1:0] tag_out,
  output logic             busy
);

  localparam int C = WIDTH / STAGES;

  logic             adv;
  logic [WIDTH-1:0] b_eff;

  // Stage registers, index k = pipeline position (STAGES-1 is the output).
  logic [STAGES-1:0] vld_p;
  logic [WIDTH-1:0]  a_p   [STAGES];
  logic [WIDTH-1:0]  b_p   [STAGES];
  logic [WIDTH-1:0]  s_p   [STAGES];
  logic [STAGES-1:0] cy_p;
  logic [TAG_W-1:0]  tag_p [STAGES];

  // Values arriving at each stage register on the next advance.
  logic [STAGES-1:0] vld_src;
  logic [WIDTH-1:0]  a_src   [STAGES];
  logic [WIDTH-1:0]  b_src   [STAGES];
  logic [WIDTH-1:0]  s_src   [STAGES];
  logic [WIDTH-1:0]  s_nxt   [STAGES];
  logic [STAGES-1:0] cin_src;
  logic [TAG_W-1:0]  tag_src [STAGES];
  logic [C-1:0]      s_chunk [STAGES];
  logic [STAGES-1:0] cout_c;

  assign adv      = !out_valid || out_ready;
  assign in_ready = adv;

  // Subtraction is a + ~b + 1; the +1 enters as the slice-0 carry-in.
  assign b_eff = (sub == OP_SUB) ? ~b : b;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    localparam logic [WIDTH-1:0] MASK = WIDTH'({C{1'b1}}) << (k * C);

    if (k == 0) begin : g_head
      assign vld_src[k] = in_valid;
      assign a_src[k]   = a;
      assign b_src[k]   = b_eff;
      assign cin_src[k] = sub;
      assign s_src[k]   = '0;
      assign tag_src[k] = tag_in;
    end else begin : g_body
      assign vld_src[k] = vld_p[k-1];
      assign a_src[k]   = a_p[k-1];
      assign b_src[k]   = b_p[k-1];
      assign cin_src[k] = cy_p[k-1];
      assign s_src[k]   = s_p[k-1];
      assign tag_src[k] = tag_p[k-1];
    end

    add_chunk #(.C(C)) u_chunk (
      .a    (a_src[k][k*C +: C]),
      .b    (b_src[k][k*C +: C]),
      .cin  (cin_src[k]),
      .s    (s_chunk[k]),
      .cout (cout_c[k])
    );

    // Splice this stage's slice into the partially built sum.
    assign s_nxt[k] = (s_src[k] & ~MASK) | (WIDTH'(s_chunk[k]) << (k * C));
  end

  // ---- stage boundary: valid bits (control, reset) ----
  always_ff @(posedge clk) begin
    if (reset) begin
      vld_p <= '0;
    end else if (adv) begin
      vld_p <= vld_src;
    end
  end

  // ---- stage boundary: datapath registers (no reset) ----
  always_ff @(posedge clk) begin
    if (adv) begin
      for (int k = 0; k < STAGES; k++) begin
        a_p[k]   <= a_src[k];
        b_p[k]   <= b_src[k];
        s_p[k]   <= s_nxt[k];
        cy_p[k]  <= cout_c[k];
        tag_p[k] <= tag_src[k];
      end
    end
  end

  // Data registers are never reset, so every result field is qualified by
  // the output valid bit; this also forces them to zero during reset.
  assign out_valid = vld_p[STAGES-1];
  assign busy      = |vld_p;
  assign sum       = out_valid ? s_p[STAGES-1] : '0;
  assign carry     = out_valid && cy_p[STAGES-1];
  assign overflow  = out_valid && signed_ovf(a_p[STAGES-1][WIDTH-1],
                                             b_p[STAGES-1][WIDTH-1],
                                             s_p[STAGES-1][WIDTH-1]);
  assign zero      = out_valid && (s_p[STAGES-1] == '0);
  assign tag_out   = out_valid ? tag_p[STAGES-1] : '0;

endmodule

// File: tb/tb_pipelined_add_sub.sv
module tb_pipelined_add_sub;

  typedef struct {
    logic [31:0] sum;
    logic        carry;
    logic        ovf;
    logic        zero;
    logic [4:0]  tag;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  // dut0: WIDTH=32, STAGES=4
  logic        iv0, ir0, sb0, ov0, or0, cy0, of0, z0, bz0;
  logic [31:0] a0, b0, s0;
  logic [4:0]  ti0, to0;
  // dut1: WIDTH=8, STAGES=2
  logic        iv1, ir1, sb1, ov1, or1, cy1, of1, z1, bz1;
  logic [7:0]  a1, b1, s1;
  logic [4:0]  ti1, to1;
  // dut2: WIDTH=32, STAGES=1
  logic        iv2, ir2, sb2, ov2, or2, cy2, of2, z2, bz2;
  logic [31:0] a2, b2, s2;
  logic [4:0]  ti2, to2;

  exp_t q0[$];
  exp_t q1[$];
  exp_t q2[$];

  pipelined_add_sub #(.WIDTH(32), .STAGES(4), .TAG_W(5)) dut0 (
    .clk(clk), .reset(rst), .in_valid(iv0), .in_ready(ir0), .a(a0), .b(b0),
    .sub(sb0), .tag_in(ti0), .out_valid(ov0), .out_ready(or0), .sum(s0),
    .carry(cy0), .overflow(of0), .zero(z0), .tag_out(to0), .busy(bz0));

  pipelined_add_sub #(.WIDTH(8), .STAGES(2), .TAG_W(5)) dut1 (
    .clk(clk), .reset(rst), .in_valid(iv1), .in_ready(ir1), .a(a1), .b(b1),
    .sub(sb1), .tag_in(ti1), .out_valid(ov1), .out_ready(or1), .sum(s1),
    .carry(cy1), .overflow(of1), .zero(z1), .tag_out(to1), .busy(bz1));

  pipelined_add_sub #(.WIDTH(32), .STAGES(1), .TAG_W(5)) dut2 (
    .clk(clk), .reset(rst), .in_valid(iv2), .in_ready(ir2), .a(a2), .b(b2),
    .sub(sb2), .tag_in(ti2), .out_valid(ov2), .out_ready(or2), .sum(s2),
    .carry(cy2), .overflow(of2), .zero(z2), .tag_out(to2), .busy(bz2));

  // Reference: plain unsigned and signed integer arithmetic on w-bit values.
  function automatic exp_t model(input int w, input logic [31:0] a,
                                 input logic [31:0] b, input logic sub,
                                 input logic [4:0] tag);
    exp_t e;
    longint m, ua, ub, sa, sb, r, full;
    m  = (longint'(1) << w) - 1;
    ua = longint'(a) & m;
    ub = longint'(b) & m;
    sa = ((ua >> (w - 1)) != 0) ? ua - (m + 1) : ua;
    sb = ((ub >> (w - 1)) != 0) ? ub - (m + 1) : ub;
    if (sub) begin
      full    = ua - ub;
      r       = sa - sb;
      e.carry = (ua >= ub);
    end else begin
      full    = ua + ub;
      r       = sa + sb;
      e.carry = (full > m);
    end
    e.sum  = 32'(full & m);
    e.zero = ((full & m) == 0);
    e.ovf  = (r > (m >> 1)) || (r < -((m >> 1) + 1));
    e.tag  = tag;
    return e;
  endfunction

  task automatic cmp(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_res(input string nm, input exp_t e, input logic [31:0] s,
                         input logic c, input logic o, input logic z,
                         input logic [4:0] t);
    cmp({nm, ".sum"},      s,         e.sum);
    cmp({nm, ".carry"},    32'(c),    32'(e.carry));
    cmp({nm, ".overflow"}, 32'(o),    32'(e.ovf));
    cmp({nm, ".zero"},     32'(z),    32'(e.zero));
    cmp({nm, ".tag"},      32'(t),    32'(e.tag));
  endtask

  task automatic fail_now(input string name);
    n_chk++;
    n_fail++;
    $display("FAIL %s at %0t", name, $time);
  endtask

  // ---------------- monitors ----------------
  logic stall0 = 1'b0, stall1 = 1'b0, stall2 = 1'b0;
  logic saw_full0 = 1'b0;
  exp_t held0, held1, held2;

  always @(negedge clk) begin : mon0
    exp_t e;
    if (rst) begin
      stall0 = 1'b0;
    end else begin
      cmp("in_ready0", 32'(ir0), 32'(!ov0 || or0));
      if (ov0) cmp("busy0", 32'(bz0), 32'd1);
      if (stall0) chk_res("stable0", held0, s0, cy0, of0, z0, to0);
      if (ov0 && or0) begin
        if (q0.size() == 0) fail_now("unexpected0");
        else begin
          e = q0.pop_front();
          chk_res("res0", e, s0, cy0, of0, z0, to0);
        end
      end
      if (!ir0) saw_full0 = 1'b1;
      stall0 = ov0 && !or0;
      held0  = '{sum: s0, carry: cy0, ovf: of0, zero: z0, tag: to0};
    end
  end

  always @(negedge clk) begin : mon1
    exp_t e;
    if (rst) begin
      stall1 = 1'b0;
    end else begin
      cmp("in_ready1", 32'(ir1), 32'(!ov1 || or1));
      if (stall1) chk_res("stable1", held1, 32'(s1), cy1, of1, z1, to1);
      if (ov1 && or1) begin
        if (q1.size() == 0) fail_now("unexpected1");
        else begin
          e = q1.pop_front();
          chk_res("res1", e, 32'(s1), cy1, of1, z1, to1);
        end
      end
      stall1 = ov1 && !or1;
      held1  = '{sum: 32'(s1), carry: cy1, ovf: of1, zero: z1, tag: to1};
    end
  end

  always @(negedge clk) begin : mon2
    exp_t e;
    if (rst) begin
      stall2 = 1'b0;
    end else begin
      cmp("in_ready2", 32'(ir2), 32'(!ov2 || or2));
      if (stall2) chk_res("stable2", held2, s2, cy2, of2, z2, to2);
      if (ov2 && or2) begin
        if (q2.size() == 0) fail_now("unexpected2");
        else begin
          e = q2.pop_front();
          chk_res("res2", e, s2, cy2, of2, z2, to2);
        end
      end
      stall2 = ov2 && !or2;
      held2  = '{sum: s2, carry: cy2, ovf: of2, zero: z2, tag: to2};
    end
  end

  // ---------------- drivers ----------------
  // Offer one op on dut0 and return just after the edge that accepted it.
  task automatic issue0(input logic [31:0] a, input logic [31:0] b,
                        input logic sub, input logic [4:0] tag);
    logic took;
    int   g;
    @(posedge clk); #1;
    a0 = a; b0 = b; sb0 = sub; ti0 = tag; iv0 = 1'b1;
    g = 0;
    do begin
      @(negedge clk); took = ir0;
      @(posedge clk); #1;
      g++;
    end while (!took && g < 200);
    iv0 = 1'b0;
    if (!took) fail_now("issue0_timeout");
    else q0.push_back(model(32, a, b, sub, tag));
  endtask

  // Issue into an empty dut0 and measure edges from acceptance to out_valid.
  task automatic lat0(input logic [31:0] a, input logic [31:0] b,
                      input logic sub, input logic [4:0] tag);
    int n;
    issue0(a, b, sub, tag);
    n = 1;
    forever begin
      @(negedge clk);
      if (ov0 || n >= 20) break;
      @(posedge clk); n++;
    end
    cmp("latency0", 32'(n), 32'd4);
  endtask

  task automatic sweep1();
    int   sent = 0, guard = 0;
    logic took = 1'b0;
    exp_t pend;
    iv1 = 1'b0;
    while (sent < 1000 && guard < 20000) begin
      @(posedge clk); #1; guard++;
      if (took) begin q1.push_back(pend); sent++; end
      or1 = ($urandom_range(0, 3) != 0);
      if (sent >= 1000) iv1 = 1'b0;
      else if (!iv1 || took) begin
        iv1 = ($urandom_range(0, 4) != 0);
        a1  = ($urandom_range(0, 7) == 0) ? 8'h80 : 8'($urandom);
        b1  = ($urandom_range(0, 7) == 0) ? a1 : 8'($urandom);
        sb1 = 1'($urandom);
        ti1 = 5'($urandom);
        pend = model(8, 32'(a1), 32'(b1), sb1, ti1);
      end
      @(negedge clk); took = iv1 && ir1;
    end
    iv1 = 1'b0; or1 = 1'b1;
    if (sent < 1000) fail_now("sweep1_timeout");
  endtask

  task automatic sweep2();
    int   sent = 0, guard = 0;
    logic took = 1'b0;
    exp_t pend;
    iv2 = 1'b0;
    while (sent < 1000 && guard < 20000) begin
      @(posedge clk); #1; guard++;
      if (took) begin q2.push_back(pend); sent++; end
      or2 = ($urandom_range(0, 3) != 0);
      if (sent >= 1000) iv2 = 1'b0;
      else if (!iv2 || took) begin
        iv2 = ($urandom_range(0, 4) != 0);
        a2  = ($urandom_range(0, 7) == 0) ? 32'h7FFF_FFFF : $urandom;
        b2  = ($urandom_range(0, 7) == 0) ? a2 : $urandom;
        sb2 = 1'($urandom);
        ti2 = 5'($urandom);
        pend = model(32, a2, b2, sb2, ti2);
      end
      @(negedge clk); took = iv2 && ir2;
    end
    iv2 = 1'b0; or2 = 1'b1;
    if (sent < 1000) fail_now("sweep2_timeout");
  endtask

  // ---------------- main sequence ----------------
  initial begin : main
    int n, g;
    rst = 1'b1;
    iv0 = 0; a0 = 0; b0 = 0; sb0 = 0; ti0 = 0; or0 = 1;
    iv1 = 0; a1 = 0; b1 = 0; sb1 = 0; ti1 = 0; or1 = 1;
    iv2 = 0; a2 = 0; b2 = 0; sb2 = 0; ti2 = 0; or2 = 1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    cmp("rst.out_valid0", 32'(ov0), 0);
    cmp("rst.busy0",      32'(bz0), 0);
    cmp("rst.sum0",       s0,       0);
    cmp("rst.flags0",     32'({cy0, of0, z0}), 0);
    cmp("rst.tag0",       32'(to0), 0);
    cmp("rst.out_valid1", 32'(ov1), 0);
    cmp("rst.out_valid2", 32'(ov2), 0);
    @(posedge clk); #1 rst = 1'b0;

    // carry/zero wrap, signed overflow both directions, borrow, equal sub
    lat0(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 5'd3);
    lat0(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 5'd4);
    lat0(32'h8000_0000, 32'h0000_0001, 1'b1, 5'd5);
    lat0(32'd5, 32'd7, 1'b1, 5'd6);
    lat0(32'd9, 32'd9, 1'b1, 5'd7);

    // backpressure while streaming 8 ops
    saw_full0 = 1'b0;
    fork
      begin
        for (int i = 0; i < 8; i++) issue0($urandom, $urandom, 1'($urandom), 5'(i));
      end
      begin
        repeat (4) @(posedge clk);
        #1 or0 = 1'b0;
        repeat (4) @(posedge clk);
        #1 or0 = 1'b1;
      end
    join
    g = 0;
    while ((q0.size() != 0 || bz0) && g < 100) begin @(posedge clk); g++; end
    @(negedge clk);
    cmp("bp.drained0", 32'(q0.size()), 0);
    cmp("bp.in_ready_fell", 32'(saw_full0), 1);

    // reset with three ops in flight
    issue0(32'd100, 32'd1, 1'b0, 5'd20);
    issue0(32'd200, 32'd2, 1'b0, 5'd21);
    issue0(32'd300, 32'd3, 1'b1, 5'd22);
    rst = 1'b1;
    q0.delete();
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    cmp("mid_rst.out_valid0", 32'(ov0), 0);
    cmp("mid_rst.busy0",      32'(bz0), 0);
    cmp("mid_rst.sum0",       s0,       0);
    cmp("mid_rst.flags0",     32'({cy0, of0, z0}), 0);
    cmp("mid_rst.tag0",       32'(to0), 0);
    lat0(32'h1234_5678, 32'h1111_1111, 1'b1, 5'd9);

    // latency of the other two configurations
    @(posedge clk); #1;
    a1 = 8'h7F; b1 = 8'h01; sb1 = 1'b0; ti1 = 5'd2; iv1 = 1'b1;
    a2 = 32'd5; b2 = 32'd7; sb2 = 1'b1; ti2 = 5'd3; iv2 = 1'b1;
    @(posedge clk); #1;
    iv1 = 1'b0; iv2 = 1'b0;
    q1.push_back(model(8, 32'h7F, 32'h01, 1'b0, 5'd2));
    q2.push_back(model(32, 32'd5, 32'd7, 1'b1, 5'd3));
    n = 1;
    forever begin
      @(negedge clk);
      if (ov1 || n >= 20) break;
      @(posedge clk); n++;
    end
    cmp("latency1", 32'(n), 32'd2);
    cmp("latency2", 32'(ov2 || bz2 || q2.size() == 0), 32'd1);
    @(posedge clk);

    // random sweeps with random backpressure
    fork
      sweep1();
      sweep2();
    join
    g = 0;
    while ((q0.size() + q1.size() + q2.size() != 0) && g < 200) begin
      @(posedge clk); g++;
    end
    @(negedge clk);
    cmp("end.queue0", 32'(q0.size()), 0);
    cmp("end.queue1", 32'(q1.size()), 0);
    cmp("end.queue2", 32'(q2.size()), 0);
    cmp("end.busy",   32'({bz0, bz1, bz2}), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

endmodule
